// File: rtl/tff_ctr_pkg.sv
// Shared types and next-value helpers for the T-cell modulo counter.
// Helpers work on a 64-bit word so any legal counter width can use them.
package tff_ctr_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CTR_MAX_W = 63;
    typedef logic [63:0] ctr_word_t;

    function automatic ctr_word_t tff_next(input ctr_word_t count, input logic up,
                                           input ctr_word_t modulus);
        if (up)
            return (count == modulus - 64'd1) ? 64'd0 : count + 64'd1;
        else
            return (count == 64'd0) ? modulus - 64'd1 : count - 64'd1;
    endfunction

    function automatic ctr_word_t tff_clamp(input ctr_word_t v, input ctr_word_t modulus);
        return (v >= modulus) ? modulus - 64'd1 : v;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle storage cell: q inverts on a clock edge whenever t is high.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q_q <= 1'b0;
        else if (t)
            q_q <= ~q_q;
    end

    assign q = q_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Programmable modulo-N up/down counter; the FSM only ever drives toggle
// enables into a bank of T cells, the count is read back from their Q bits.
module tff_mod_counter
    import tff_ctr_pkg::*;
#(
    parameter int unsigned       WIDTH   = 4,
    parameter longint unsigned   MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             up,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] toggle,
    output logic             tc,
    output logic             busy
);

    localparam ctr_word_t MOD_W = ctr_word_t'(MODULUS);

    generate
        if (WIDTH < 1 || WIDTH > CTR_MAX_W || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_params
            $error("tff_mod_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    state_t           state_q, state_d;
    logic             oneshot_q, oneshot_d;
    logic             tc_q, tc_d;
    logic             busy_q;
    logic [WIDTH-1:0] toggle_q;
    logic [WIDTH-1:0] t_d;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] clamp_val;
    logic [WIDTH-1:0] term_val;

    assign next_val  = WIDTH'(tff_next(ctr_word_t'(count), up, MOD_W));
    assign clamp_val = WIDTH'(tff_clamp(ctr_word_t'(load_val), MOD_W));
    assign term_val  = up ? WIDTH'(MOD_W - 64'd1) : '0;

    always_comb begin
        state_d   = state_q;
        oneshot_d = oneshot_q;
        tc_d      = 1'b0;
        t_d       = '0;
        if (load) begin
            t_d = count ^ clamp_val;
            // DONE is a one-cycle state, so it still retires even under a load.
            if (state_q == DONE)
                state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = RUN;
                        oneshot_d = oneshot;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (en) begin
                        if (count == term_val) begin
                            tc_d = 1'b1;
                            if (oneshot_q)
                                state_d = DONE;
                            else
                                t_d = count ^ next_val;
                        end else begin
                            t_d = count ^ next_val;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            oneshot_q <= 1'b0;
            tc_q      <= 1'b0;
            busy_q    <= 1'b0;
            toggle_q  <= '0;
        end else begin
            state_q   <= state_d;
            oneshot_q <= oneshot_d;
            tc_q      <= tc_d;
            busy_q    <= (state_d == RUN);
            toggle_q  <= t_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cells
            tff_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .t     (t_d[gi]),
                .q     (count[gi])
            );
        end
    endgenerate

    assign toggle = toggle_q;
    assign tc     = tc_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed bench for tff_mod_counter (WIDTH=4, MODULUS=10) with a cycle model.
module tb_tff_mod_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, stop, en, up, oneshot, load;
    logic [W-1:0] load_val;
    logic [W-1:0] count, toggle;
    logic         tc, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int tc_hits;

    // Model: 0 = idle, 1 = run, 2 = done
    int m_count  = 0;
    int m_toggle = 0;
    int m_tc     = 0;
    int m_mode   = 0;
    int m_os     = 0;

    always #5 clk = ~clk;

    tff_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .up       (up),
        .oneshot  (oneshot),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .toggle   (toggle),
        .tc       (tc),
        .busy     (busy)
    );

    task automatic chk(input string nm, input int act, input int exp_v, input bit verbose);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("[%0t] FAIL %s: got %0d, expected %0d", $time, nm, act, exp_v);
        end else if (verbose) begin
            $display("[%0t] ok   %s = %0d", $time, nm, act);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        int c_new, mode_new, tc_new, os_new, term;
        if (!reset) begin
            m_count  <= 0;
            m_toggle <= 0;
            m_tc     <= 0;
            m_mode   <= 0;
            m_os     <= 0;
        end else begin
            c_new    = m_count;
            mode_new = (m_mode == 2) ? 0 : m_mode;
            tc_new   = 0;
            os_new   = m_os;
            term     = up ? M - 1 : 0;
            if (load) begin
                c_new = (int'(load_val) >= M) ? M - 1 : int'(load_val);
            end else if (m_mode == 1) begin
                if (stop) begin
                    mode_new = 0;
                end else if (en) begin
                    if (m_count == term) tc_new = 1;
                    if (m_count == term && m_os != 0)
                        mode_new = 2;
                    else
                        c_new = up ? (m_count + 1) % M : (m_count + M - 1) % M;
                end
            end else if (m_mode == 0 && start) begin
                mode_new = 1;
                os_new   = int'(oneshot);
            end
            m_toggle <= m_count ^ c_new;
            m_count  <= c_new;
            m_tc     <= tc_new;
            m_mode   <= mode_new;
            m_os     <= os_new;
        end
    end

    always @(negedge clk) begin
        chk("cyc_count",  int'(count),  m_count,  1'b0);
        chk("cyc_toggle", int'(toggle), m_toggle, 1'b0);
        chk("cyc_tc",     int'(tc),     m_tc,     1'b0);
        chk("cyc_busy",   int'(busy),   (m_mode == 1) ? 1 : 0, 1'b0);
    end

    int os_cnt[4]  = '{2, 1, 0, 0};
    int os_tc[4]   = '{0, 0, 0, 1};
    int os_busy[4] = '{1, 1, 1, 0};

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; up = 1'b1;
        oneshot = 1'b0; load = 1'b0; load_val = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset then idle with en high
        en = 1'b1; tc_hits = 0;
        repeat (5) begin @(negedge clk); if (tc) tc_hits++; end
        chk("idle_count", int'(count), 0, 1'b1);
        chk("idle_busy", int'(busy), 0, 1'b1);
        chk("idle_tc_hits", tc_hits, 0, 1'b1);

        // Free-run up
        start = 1'b1; oneshot = 1'b0; up = 1'b1; en = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("fr_busy", int'(busy), 1, 1'b1);
        chk("fr_first_count", int'(count), 0, 1'b1);
        tc_hits = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (tc) tc_hits++;
            if (k == 10) begin
                chk("fr_wrap_toggle", int'(toggle), 9, 1'b1);
                chk("fr_wrap_tc", int'(tc), 1, 1'b1);
            end
        end
        chk("fr_end_count", int'(count), 4, 1'b1);
        chk("fr_tc_hits", tc_hits, 2, 1'b1);

        // Down wrap 0 -> 9 while free-running
        up = 1'b0;
        repeat (4) @(negedge clk);
        chk("dn_count0", int'(count), 0, 1'b1);
        @(negedge clk);
        chk("dn_wrap_count", int'(count), 9, 1'b1);
        chk("dn_wrap_tc", int'(tc), 1, 1'b1);
        stop = 1'b1; en = 1'b0;
        @(negedge clk); stop = 1'b0;
        chk("stop_busy", int'(busy), 0, 1'b1);

        // One-shot down from 3
        load = 1'b1; load_val = 4'd3;
        @(negedge clk); load = 1'b0;
        chk("os_load", int'(count), 3, 1'b1);
        start = 1'b1; oneshot = 1'b1; up = 1'b0; en = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("os_start_busy", int'(busy), 1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("os_count_%0d", k), int'(count), os_cnt[k], 1'b1);
            chk($sformatf("os_tc_%0d", k), int'(tc), os_tc[k], 1'b1);
            chk($sformatf("os_busy_%0d", k), int'(busy), os_busy[k], 1'b1);
        end
        start = 1'b1;  // offered during DONE, must be ignored
        @(negedge clk); start = 1'b0;
        chk("done_start_ignored", int'(busy), 0, 1'b1);
        @(negedge clk);
        chk("idle_after_done", int'(busy), 0, 1'b1);

        // Load clamp beats stop
        start = 1'b1; oneshot = 1'b0; up = 1'b1; en = 1'b0;
        @(negedge clk); start = 1'b0;
        load = 1'b1; load_val = 4'd14; stop = 1'b1;
        @(negedge clk); load = 1'b0; stop = 1'b0;
        chk("clamp_count", int'(count), 9, 1'b1);
        chk("clamp_toggle", int'(toggle), 9, 1'b1);
        chk("clamp_tc", int'(tc), 0, 1'b1);
        chk("clamp_busy", int'(busy), 1, 1'b1);

        // Gated enable then stop
        load = 1'b1; load_val = 4'd5;
        @(negedge clk); load = 1'b0;
        chk("gate_load_toggle", int'(toggle), 12, 1'b1);
        en = 1'b1; @(negedge clk); chk("gate_c6", int'(count), 6, 1'b1);
        en = 1'b0; @(negedge clk); chk("gate_hold", int'(count), 6, 1'b1);
        chk("gate_hold_toggle", int'(toggle), 0, 1'b1);
        en = 1'b1; @(negedge clk); chk("gate_c7", int'(count), 7, 1'b1);
        en = 1'b0; stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        chk("stop_count", int'(count), 7, 1'b1);
        chk("stop_busy2", int'(busy), 0, 1'b1);

        // Asynchronous reset mid-run at count 6
        start = 1'b1; up = 1'b1; en = 1'b0;
        @(negedge clk); start = 1'b0;
        load = 1'b1; load_val = 4'd6;
        @(negedge clk); load = 1'b0;
        chk("ar_pre_count", int'(count), 6, 1'b1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("ar_count", int'(count), 0, 1'b1);
        chk("ar_busy", int'(busy), 0, 1'b1);
        @(negedge clk); reset = 1'b1; en = 1'b1;
        repeat (2) @(negedge clk);
        chk("ar_idle_count", int'(count), 0, 1'b1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("ar_restart_busy", int'(busy), 1, 1'b1);
        @(negedge clk); chk("ar_c1", int'(count), 1, 1'b1);
        @(negedge clk); chk("ar_c2", int'(count), 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
